// File: rtl/int_arbiter_if.sv
// int_arbiter_if: interrupt lines, register port and eip handshake of the external interrupt arbiter.
interface int_arbiter_if #(parameter int NSRC = 8);
    logic [NSRC-1:0] irq;
    logic [1:0]      a;
    logic [31:0]     d;
    logic            we;
    logic [31:0]     spo;
    logic            eip;
    logic            eip_reply;
    modport master (output irq, a, d, we, eip_reply, input spo, eip);
    modport slave  (input irq, a, d, we, eip_reply, output spo, eip);
endinterface

// File: rtl/int_arbiter.sv
// int_arbiter: edge-detects interrupt sources, masks them with ENABLE and claims the lowest enabled pending one.
module int_arbiter #(parameter int NSRC = 8) (
    input logic clk,
    input logic rst,
    int_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
    state_t          state;
    logic [NSRC-1:0] pending, enable, irq_prev, rise, elig, w1c, claim_clr;
    logic [4:0]      claim_id, sel_id;
    logic            eip, take, complete, in_service;
    assign rise       = bus.irq & ~irq_prev;
    assign elig       = pending & enable;
    assign take       = state == IDLE && |elig;
    assign w1c        = (bus.we && bus.a == 2'd0) ? bus.d[NSRC-1:0] : '0;
    assign claim_clr  = take ? NSRC'(1) << sel_id : '0;
    assign complete   = bus.we && bus.a == 2'd3 && state == SERVICE && bus.d[4:0] == claim_id;
    assign in_service = state == ASSERT || state == SERVICE;
    assign bus.eip    = eip;
    assign bus.spo    = bus.a == 2'd0 ? 32'(pending) :
                        bus.a == 2'd1 ? 32'(enable) :
                        bus.a == 2'd2 ? {in_service, 26'b0, claim_id} : 32'd0;
    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        sel_id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (elig[i]) sel_id = 5'(i);
    end
    always_ff @(posedge clk) begin
        irq_prev <= bus.irq;
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            enable   <= '0;
            claim_id <= '0;
            eip      <= 1'b0;
        end else begin
            // A fresh edge outranks both the W1C and the claim clear.
            pending <= (pending & ~w1c & ~claim_clr) | rise;
            if (bus.we && bus.a == 2'd1) enable <= bus.d[NSRC-1:0];
            case (state)
                IDLE: if (take) begin
                    claim_id <= sel_id;
                    eip      <= 1'b1;
                    state    <= ASSERT;
                end
                ASSERT: if (bus.eip_reply) begin
                    eip   <= 1'b0;
                    state <= SERVICE;
                end
                SERVICE: if (complete) state <= IDLE;
                default: begin
                    eip   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
